// File: rtl/ifmap_noc_scheduler_if.sv
// Ifmap multicast NoC port: a tagged payload moved by a valid/ready handshake.
// The scheduler drives the master side and the PE-array NoC router sits on the slave side.
interface ifmap_noc_scheduler_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 5
);
    logic                     noc_valid;
    logic                     noc_ready;
    logic [DATA_WIDTH-1:0]    noc_data;
    logic [ROW_TAG_WIDTH-1:0] noc_row_tag;
    logic [COL_TAG_WIDTH-1:0] noc_col_tag;

    modport master (
        output noc_valid,
        output noc_data,
        output noc_row_tag,
        output noc_col_tag,
        input  noc_ready
    );

    modport slave (
        input  noc_valid,
        input  noc_data,
        input  noc_row_tag,
        input  noc_col_tag,
        output noc_ready
    );
endinterface

// File: rtl/ifmap_noc_scheduler.sv
// Streams r*D ifmap words from the GLB onto the multicast NoC, each tagged with its {row, col} ID.
// Latency: first GLB read 1 cycle after start, packet 1 cycle after its read; 1 packet/cycle at full ready.
// Backpressure: 2-entry output buffer; reads issue only while buffered + in-flight words < 2, so nothing is dropped.
module ifmap_noc_scheduler #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 12,
    parameter int D_WIDTH       = 8,
    parameter int U_WIDTH       = 3,
    parameter int r_WIDTH       = 2,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [D_WIDTH-1:0]    cfg_D,
    input  logic [U_WIDTH-1:0]    cfg_U,
    input  logic [r_WIDTH-1:0]    cfg_r,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    output logic                  glb_rd_en,
    output logic [ADDR_WIDTH-1:0] glb_rd_addr,
    input  logic [DATA_WIDTH-1:0] glb_rd_data,
    ifmap_noc_scheduler_if.master noc,
    output logic                  busy,
    output logic                  done
);
    localparam int N_WIDTH = D_WIDTH + r_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    // latched layer config
    logic [N_WIDTH-1:0]       n_q;
    logic [U_WIDTH-1:0]       u_q;
    logic [r_WIDTH-1:0]       r_q;
    logic [ADDR_WIDTH-1:0]    base_q;
    logic [COL_TAG_WIDTH-1:0] max_col_q;

    // issue-side counters
    logic [N_WIDTH-1:0]       issue_cnt;
    logic [r_WIDTH-1:0]       r_idx;
    logic [U_WIDTH-1:0]       u_idx;
    logic [COL_TAG_WIDTH-1:0] col_idx;
    logic [ROW_TAG_WIDTH-1:0] row_now;

    // one read in flight plus a 2-entry FIFO
    logic                     inflight_q;
    logic [ROW_TAG_WIDTH-1:0] infl_row_q;
    logic [COL_TAG_WIDTH-1:0] infl_col_q;
    logic [DATA_WIDTH-1:0]    buf_dat [2];
    logic [ROW_TAG_WIDTH-1:0] buf_row [2];
    logic [COL_TAG_WIDTH-1:0] buf_col [2];
    logic                     wr_ptr, rd_ptr;
    logic [1:0]               occ_q, occ_next, pending;
    logic                     show_buf, fire, push, pop;

    logic                     start_acc, last_rd;
    logic [N_WIDTH-1:0]       n_in;

    assign start_acc = (state_q == S_IDLE) && start;
    assign n_in      = N_WIDTH'(cfg_D) * N_WIDTH'(cfg_r);
    assign pending   = occ_q + {1'b0, inflight_q};
    assign last_rd   = glb_rd_en && (issue_cnt == n_q - N_WIDTH'(1));
    assign row_now   = ROW_TAG_WIDTH'(u_idx) + (ROW_TAG_WIDTH'(r_idx) << 2);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (n_in == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (last_rd) state_d = S_DRAIN;
            // leave as the last packet hands off, so done lands the very next cycle
            S_DRAIN: if (pending == {1'b0, fire}) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        glb_rd_en   = (state_q == S_ISSUE) && (pending < 2'd2);
        glb_rd_addr = glb_rd_en ? base_q + ADDR_WIDTH'(issue_cnt) : '0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

    // ---------------- NoC side: buffer head, else the word arriving this cycle ----------------
    assign show_buf        = (occ_q != 2'd0);
    assign noc.noc_valid   = show_buf || inflight_q;
    assign noc.noc_data    = show_buf ? buf_dat[rd_ptr] : (inflight_q ? glb_rd_data : '0);
    assign noc.noc_row_tag = show_buf ? buf_row[rd_ptr] : (inflight_q ? infl_row_q : '0);
    assign noc.noc_col_tag = show_buf ? buf_col[rd_ptr] : (inflight_q ? infl_col_q : '0);

    assign fire     = noc.noc_valid && noc.noc_ready;
    assign pop      = fire && show_buf;
    assign push     = inflight_q && !(fire && !show_buf);
    assign occ_next = occ_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q        <= '0;
            u_q        <= '0;
            r_q        <= '0;
            base_q     <= '0;
            max_col_q  <= '0;
            issue_cnt  <= '0;
            r_idx      <= '0;
            u_idx      <= '0;
            col_idx    <= '0;
            inflight_q <= 1'b0;
            infl_row_q <= '0;
            infl_col_q <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_dat[i] <= '0;
                buf_row[i] <= '0;
                buf_col[i] <= '0;
            end
        end else begin
            if (start_acc) begin
                n_q       <= n_in;
                u_q       <= (cfg_U == '0) ? U_WIDTH'(1) : cfg_U;
                r_q       <= cfg_r;
                base_q    <= cfg_base;
                max_col_q <= COL_TAG_WIDTH'(cfg_D >> (cfg_U >> 1));
                issue_cnt <= '0;
                r_idx     <= '0;
                u_idx     <= '0;
                col_idx   <= '0;
            end else if (glb_rd_en) begin
                issue_cnt <= issue_cnt + N_WIDTH'(1);
                // r innermost, then u, then column with wrap at max_col
                if (r_idx == r_q - r_WIDTH'(1)) begin
                    r_idx <= '0;
                    if (u_idx == u_q - U_WIDTH'(1)) begin
                        u_idx   <= '0;
                        col_idx <= (col_idx == max_col_q) ? '0 : col_idx + COL_TAG_WIDTH'(1);
                    end else begin
                        u_idx <= u_idx + U_WIDTH'(1);
                    end
                end else begin
                    r_idx <= r_idx + r_WIDTH'(1);
                end
            end

            inflight_q <= glb_rd_en;
            if (glb_rd_en) begin
                infl_row_q <= row_now;
                infl_col_q <= col_idx;
            end

            if (push) begin
                buf_dat[wr_ptr] <= glb_rd_data;
                buf_row[wr_ptr] <= infl_row_q;
                buf_col[wr_ptr] <= infl_col_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ_q <= occ_next;
        end
    end
endmodule

// File: tb/tb_ifmap_noc_scheduler.sv
// Randomized bench for ifmap_noc_scheduler: a GLB memory model feeds reads, and every packet
// is compared with a sequence computed from the tag-ordering rules with plain arithmetic.
module tb_ifmap_noc_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_D;
    logic [2:0]  cfg_U;
    logic [1:0]  cfg_r;
    logic [11:0] cfg_base;
    logic        glb_rd_en;
    logic [11:0] glb_rd_addr;
    logic [15:0] glb_rd_data;
    logic        busy, done;

    ifmap_noc_scheduler_if #(.DATA_WIDTH(16), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(5)) noc_if ();

    ifmap_noc_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_D       (cfg_D),
        .cfg_U       (cfg_U),
        .cfg_r       (cfg_r),
        .cfg_base    (cfg_base),
        .glb_rd_en   (glb_rd_en),
        .glb_rd_addr (glb_rd_addr),
        .glb_rd_data (glb_rd_data),
        .noc         (noc_if),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [15:0] mem [4096];
    logic        rd_pend = 1'b0;
    logic [11:0] rd_addr_l = '0;

    // monitor / scoreboard state
    logic        mon_en = 1'b0;
    int          exp_n, exp_base, rd_cnt, hs_cnt;
    int          start_cyc, first_rd_cyc, last_hs_cyc;
    logic        done_seen, seen_valid, stall_prev;
    logic [24:0] held_pkt, mon_pkt;
    logic [24:0] exp_pkt [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // GLB model: data for a read appears during the following cycle
    always @(negedge clk) begin
        rd_pend   = glb_rd_en;
        rd_addr_l = glb_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        glb_rd_data = rd_pend ? mem[rd_addr_l] : 16'($urandom);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       noc_if.noc_ready = 1'b1;
            1:       noc_if.noc_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: noc_if.noc_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (reset && mon_en) begin
            check("busy", 32'(busy), 32'((cyc > start_cyc) && !done_seen));
            if (glb_rd_en) begin
                check("rd_in_range", 32'(rd_cnt < exp_n), 32'd1);
                check("rd_addr", 32'(glb_rd_addr), 32'((exp_base + rd_cnt) % 4096));
                check("rd_pending", 32'((rd_cnt - hs_cnt) < 2), 32'd1);
                if (rd_cnt == 0) begin
                    check("first_rd_lat", 32'(cyc), 32'(start_cyc + 1));
                    first_rd_cyc = cyc;
                end
                rd_cnt++;
            end
            if (stall_prev) check("valid_held", 32'(noc_if.noc_valid), 32'd1);
            if (noc_if.noc_valid) begin
                mon_pkt = {noc_if.noc_data, noc_if.noc_row_tag, noc_if.noc_col_tag};
                if (stall_prev) check("hold_stable", 32'(mon_pkt), 32'(held_pkt));
                if (!seen_valid) check("first_pkt_lat", 32'(cyc), 32'(first_rd_cyc + 1));
                seen_valid = 1'b1;
                if (noc_if.noc_ready) begin
                    check("pkt_in_range", 32'(hs_cnt < exp_n), 32'd1);
                    if (hs_cnt < exp_n) check("pkt", 32'(mon_pkt), 32'(exp_pkt[hs_cnt]));
                    if (ready_mode == 0 && hs_cnt > 0) check("no_bubble", 32'(cyc), 32'(last_hs_cyc + 1));
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
                stall_prev = !noc_if.noc_ready;
                held_pkt   = mon_pkt;
            end else begin
                stall_prev = 1'b0;
            end
            if (done) begin
                check("single_done", 32'(done_seen), 32'd0);
                check("done_cycle", 32'(cyc), 32'((exp_n == 0) ? start_cyc + 1 : last_hs_cyc + 1));
                check("done_count", 32'(hs_cnt), 32'(exp_n));
                done_seen = 1'b1;
            end
        end
    end

    task automatic run_xfer(input int d, input int u, input int r, input int base,
                            input int mode, input bit inject);
        int ueff, maxc, addr, rr, uu, cc, t;
        exp_n = d * r;
        ueff  = (u == 0) ? 1 : u;
        maxc  = (d >> (u >> 1)) % 32;
        for (int k = 0; k < exp_n; k++) begin
            rr   = k % r;
            uu   = (k / r) % ueff;
            cc   = (k / (r * ueff)) % (maxc + 1);
            addr = (base + k) % 4096;
            exp_pkt[k] = {mem[addr], 4'((uu + 4 * rr) % 16), 5'(cc)};
        end
        exp_base     = base;
        ready_mode   = mode;
        rd_cnt       = 0;
        hs_cnt       = 0;
        first_rd_cyc = -10;
        last_hs_cyc  = -10;
        done_seen    = 1'b0;
        seen_valid   = 1'b0;
        stall_prev   = 1'b0;
        cfg_D    = 8'(d);
        cfg_U    = 3'(u);
        cfg_r    = 2'(r);
        cfg_base = 12'(base);
        start    = 1'b1;
        start_cyc = cyc;
        mon_en   = 1'b1;
        wait_edge();
        start    = 1'b0;
        cfg_D    = 8'($urandom);
        cfg_U    = 3'($urandom);
        cfg_r    = 2'($urandom);
        cfg_base = 12'($urandom);
        t = 0;
        while (!done_seen && t < 2000) begin
            if (inject && t == 3) start = 1'b1;
            if (inject && t == 4) start = 1'b0;
            wait_edge();
            t++;
        end
        start = 1'b0;
        check("xfer_completed", 32'(done_seen), 32'd1);
        check("pkt_total", 32'(hs_cnt), 32'(exp_n));
        check("rd_total", 32'(rd_cnt), 32'(exp_n));
        repeat (3) wait_edge();
    endtask

    task automatic abort_test();
        mon_en     = 1'b0;
        ready_mode = 2;
        cfg_D    = 8'd8;
        cfg_U    = 3'd2;
        cfg_r    = 2'd3;
        cfg_base = 12'($urandom);
        start    = 1'b1;
        wait_edge();
        start = 1'b0;
        repeat (5) wait_edge();
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'({glb_rd_en, noc_if.noc_valid, busy, done, glb_rd_addr, noc_if.noc_data}), 32'd0);
        check("abort_tags", 32'({noc_if.noc_row_tag, noc_if.noc_col_tag}), 32'd0);
        wait_edge();
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_quiet", 32'({done, busy, glb_rd_en, noc_if.noc_valid}), 32'd0);
        end
        wait_edge();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        reset    = 1'b0;
        start    = 1'b0;
        cfg_D    = '0;
        cfg_U    = '0;
        cfg_r    = '0;
        cfg_base = '0;
        noc_if.noc_ready = 1'b1;
        glb_rd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({glb_rd_en, noc_if.noc_valid, busy, done, glb_rd_addr, noc_if.noc_data}), 32'd0);
        check("reset_tags", 32'({noc_if.noc_row_tag, noc_if.noc_col_tag}), 32'd0);
        wait_edge();
        reset = 1'b1;
        repeat (2) wait_edge();

        run_xfer(4, 1, 2, 12'h010, 0, 1'b0);   // full-rate reference case
        run_xfer(4, 1, 2, 12'h010, 1, 1'b1);   // 1-0-0-1 ready, stray start mid-run
        run_xfer(2, 2, 1, 12'h123, 0, 1'b0);   // stride 2 tags
        run_xfer(5, 1, 0, 12'h040, 0, 1'b0);   // r=0: empty transfer
        run_xfer(0, 3, 2, 12'h040, 2, 1'b0);   // D=0: empty transfer
        run_xfer(4, 1, 1, 12'hFFE, 0, 1'b0);   // address wrap
        abort_test();
        run_xfer(6, 3, 3, 12'h200, 2, 1'b0);   // full transfer after abort
        for (int i = 0; i < 12; i++) begin
            run_xfer(int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
